// File: rtl/noc_link_pkg.sv
// Shared types and helpers for the router-to-router link pipeline.
// Imported by the link top and its pipeline stage.
package noc_link_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } link_state_e;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_pipe_stage.sv
// One register slice of the link: forward flit fields plus the
// returning credit, all cleared by synchronous reset.
module noc_pipe_stage
    import noc_link_pkg::*;
#(
    parameter int FLIT_WIDTH = 128,
    parameter int DEST_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [FLIT_WIDTH-1:0] i_data,
    input  logic [DEST_WIDTH-1:0] i_dest,
    input  logic                  i_tail,
    input  logic                  i_send,
    input  logic                  i_credit,
    output logic [FLIT_WIDTH-1:0] o_data,
    output logic [DEST_WIDTH-1:0] o_dest,
    output logic                  o_tail,
    output logic                  o_send,
    output logic                  o_credit
);

    logic [FLIT_WIDTH-1:0] r_data;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_tail;
    logic                  r_send;
    logic                  r_credit;

    // Capture both directions every cycle; no stall path exists
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data   <= '0;
            r_dest   <= '0;
            r_tail   <= 1'b0;
            r_send   <= 1'b0;
            r_credit <= 1'b0;
        end else begin
            r_data   <= i_data;
            r_dest   <= i_dest;
            r_tail   <= i_tail;
            r_send   <= i_send;
            r_credit <= i_credit;
        end
    end

    assign o_data   = r_data;
    assign o_dest   = r_dest;
    assign o_tail   = r_tail;
    assign o_send   = r_send;
    assign o_credit = r_credit;

endmodule

// File: rtl/noc_link_pipe.sv
// Pipelined router-to-router link with an upstream-side monitor:
// credit occupancy, flit/packet statistics and sticky protocol errors.
module noc_link_pipe
    import noc_link_pkg::*;
#(
    parameter int NUM_PIPELINE      = 0,
    parameter int FLIT_WIDTH        = 128,
    parameter int DEST_WIDTH        = 6,
    parameter int FLIT_BUFFER_DEPTH = 8,
    parameter int STAT_WIDTH        = 32
) (
    input  logic                                   clk_noc,
    input  logic                                   rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0]                  data_in,
    input  logic [DEST_WIDTH-1:0]                  dest_in,
    input  logic                                   is_tail_in,
    input  logic                                   send_in,
    output logic                                   credit_out,
    output logic [FLIT_WIDTH-1:0]                  data_out,
    output logic [DEST_WIDTH-1:0]                  dest_out,
    output logic                                   is_tail_out,
    output logic                                   send_out,
    input  logic                                   credit_in,
    input  logic                                   stat_clear,
    output logic [credit_w(FLIT_BUFFER_DEPTH)-1:0] credits_avail,
    output logic [STAT_WIDTH-1:0]                  flit_count,
    output logic [STAT_WIDTH-1:0]                  pkt_count,
    output logic                                   err_underflow,
    output logic                                   err_overflow,
    output logic                                   err_dest_chg
);

    localparam int             CW      = credit_w(FLIT_BUFFER_DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(FLIT_BUFFER_DEPTH);
    localparam int             NP      = NUM_PIPELINE;

    // Index 0 is the link input, index NP the link output; NP=0 is a wire
    logic [FLIT_WIDTH-1:0] w_data   [NP+1];
    logic [DEST_WIDTH-1:0] w_dest   [NP+1];
    logic                  w_tail   [NP+1];
    logic                  w_send   [NP+1];
    logic                  w_credit [NP+1];

    assign w_data[0]   = data_in;
    assign w_dest[0]   = dest_in;
    assign w_tail[0]   = is_tail_in;
    assign w_send[0]   = send_in;
    assign w_credit[0] = credit_in;

    for (genvar g = 0; g < NP; g++) begin : g_stage
        noc_pipe_stage #(
            .FLIT_WIDTH (FLIT_WIDTH),
            .DEST_WIDTH (DEST_WIDTH)
        ) u_stage (
            .i_clk    (clk_noc),
            .i_rst    (rst_noc_sync),
            .i_data   (w_data[g]),
            .i_dest   (w_dest[g]),
            .i_tail   (w_tail[g]),
            .i_send   (w_send[g]),
            .i_credit (w_credit[g]),
            .o_data   (w_data[g+1]),
            .o_dest   (w_dest[g+1]),
            .o_tail   (w_tail[g+1]),
            .o_send   (w_send[g+1]),
            .o_credit (w_credit[g+1])
        );
    end

    assign data_out    = w_data[NP];
    assign dest_out    = w_dest[NP];
    assign is_tail_out = w_tail[NP];
    assign send_out    = w_send[NP];
    assign credit_out  = w_credit[NP];

    logic [CW-1:0]         r_credits;
    logic [STAT_WIDTH-1:0] r_flit_cnt;
    logic [STAT_WIDTH-1:0] r_pkt_cnt;
    logic                  r_err_uf;
    logic                  r_err_of;
    logic                  r_err_dc;
    link_state_e           r_state;
    link_state_e           w_next;
    logic [DEST_WIDTH-1:0] r_pkt_dest;
    logic                  w_latch;
    logic                  w_dc_evt;
    logic                  w_dec;
    logic                  w_inc;
    logic                  w_uf_evt;
    logic                  w_of_evt;

    // Returned credit is seen at the link output, i.e. after the back pipe
    assign w_dec    = send_in & ~credit_out;
    assign w_inc    = credit_out & ~send_in;
    assign w_uf_evt = w_dec & (r_credits == '0);
    assign w_of_evt = w_inc & (r_credits == DEPTH_C);

    // Saturating credit counter; out-of-range steps only raise errors
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_credits <= DEPTH_C;
        end else if (w_dec && !w_uf_evt) begin
            r_credits <= r_credits - CW'(1);
        end else if (w_inc && !w_of_evt) begin
            r_credits <= r_credits + CW'(1);
        end
    end

    // Free-running wrapping statistics; a clear beats a same-cycle event
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync || stat_clear) begin
            r_flit_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else begin
            r_flit_cnt <= r_flit_cnt + STAT_WIDTH'(send_in);
            r_pkt_cnt  <= r_pkt_cnt + STAT_WIDTH'(send_in & is_tail_in);
        end
    end

    // Sticky error flags, cleared only by stat_clear or reset
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync || stat_clear) begin
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
            r_err_dc <= 1'b0;
        end else begin
            r_err_uf <= r_err_uf | w_uf_evt;
            r_err_of <= r_err_of | w_of_evt;
            r_err_dc <= r_err_dc | w_dc_evt;
        end
    end

    // Packet tracker state register
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Packet tracker next state: head opens, tail closes a packet
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (send_in && !is_tail_in) w_next = IN_PKT;
            IN_PKT:  if (send_in && is_tail_in)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Packet tracker outputs: head latch and mid-packet dest check
    always_comb begin
        w_latch  = 1'b0;
        w_dc_evt = 1'b0;
        unique case (r_state)
            IDLE:    w_latch  = send_in & ~is_tail_in;
            IN_PKT:  w_dc_evt = send_in & (dest_in != r_pkt_dest);
            default: w_latch  = 1'b0;
        endcase
    end

    // Hold the head flit's destination for the rest of the packet
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            r_pkt_dest <= '0;
        end else if (w_latch) begin
            r_pkt_dest <= dest_in;
        end
    end

    assign credits_avail = r_credits;
    assign flit_count    = r_flit_cnt;
    assign pkt_count     = r_pkt_cnt;
    assign err_underflow = r_err_uf;
    assign err_overflow  = r_err_of;
    assign err_dest_chg  = r_err_dc;

endmodule

// File: tb/tb_noc_link_pipe.sv
// Scoreboard bench for noc_link_pipe: directed link scenarios followed
// by random traffic against a cycle-level reference of the link rules.
module tb_noc_link_pipe;

    localparam int N  = 2;
    localparam int D  = 8;
    localparam int FW = 128;
    localparam int DW = 6;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          send_in = 1'b0;
    logic          credit_in = 1'b0;
    logic          stat_clear = 1'b0;
    logic          credit_out;
    logic [FW-1:0] data_out;
    logic [DW-1:0] dest_out;
    logic          is_tail_out;
    logic          send_out;
    logic [3:0]    credits_avail;
    logic [SW-1:0] flit_count;
    logic [SW-1:0] pkt_count;
    logic          err_underflow;
    logic          err_overflow;
    logic          err_dest_chg;

    noc_link_pipe #(
        .NUM_PIPELINE      (N),
        .FLIT_WIDTH        (FW),
        .DEST_WIDTH        (DW),
        .FLIT_BUFFER_DEPTH (D),
        .STAT_WIDTH        (SW)
    ) dut (
        .clk_noc       (clk),
        .rst_noc_sync  (rst),
        .data_in       (data_in),
        .dest_in       (dest_in),
        .is_tail_in    (is_tail_in),
        .send_in       (send_in),
        .credit_out    (credit_out),
        .data_out      (data_out),
        .dest_out      (dest_out),
        .is_tail_out   (is_tail_out),
        .send_out      (send_out),
        .credit_in     (credit_in),
        .stat_clear    (stat_clear),
        .credits_avail (credits_avail),
        .flit_count    (flit_count),
        .pkt_count     (pkt_count),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow),
        .err_dest_chg  (err_dest_chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] d;
        logic [DW-1:0] dst;
        logic          t;
        int            due;
    } fexp_t;

    fexp_t fq[$];
    int    cqd[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    started = 0;

    // Reference state
    int          m_cred = D;
    logic [31:0] m_fc = 0;
    logic [31:0] m_pc = 0;
    bit          m_uf = 0, m_of = 0, m_dc = 0;
    bit          m_inpkt = 0;
    logic [5:0]  m_ld = 0;
    bit          cq[$];

    task automatic chk(input string nm, input logic [FW-1:0] a,
                       input logic [FW-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, a, e, cyc);
        end
    endtask

    task automatic drive(input bit s, input logic [FW-1:0] d,
                         input logic [DW-1:0] ds, input bit t,
                         input bit ci, input bit clr, input bit r);
        @(posedge clk);
        #1;
        send_in    = s;
        data_in    = d;
        dest_in    = ds;
        is_tail_in = t;
        credit_in  = ci;
        stat_clear = clr;
        rst        = r;
        if (s) fq.push_back('{d: d, dst: ds, t: t, due: cyc + N});
        if (ci) cqd.push_back(cyc + N);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, '0, '0, 0, 0, 0, 0);
    endtask

    // Reference model: credit_out is credit_in delayed N edges
    initial begin
        bit c, uf, of, dc;
        repeat (N) cq.push_back(1'b0);
        forever begin
            @(posedge clk);
            if (rst) begin
                m_cred = D; m_fc = 0; m_pc = 0;
                m_uf = 0; m_of = 0; m_dc = 0; m_inpkt = 0;
                cq.delete();
                repeat (N) cq.push_back(1'b0);
                fq.delete();
                cqd.delete();
            end else begin
                c = cq.pop_front();
                cq.push_back(credit_in);
                uf = 0; of = 0; dc = 0;
                if (send_in && !c) begin
                    if (m_cred == 0) uf = 1;
                    else m_cred--;
                end else if (c && !send_in) begin
                    if (m_cred == D) of = 1;
                    else m_cred++;
                end
                if (send_in) begin
                    if (!m_inpkt) begin
                        if (!is_tail_in) begin
                            m_inpkt = 1;
                            m_ld = dest_in;
                        end
                    end else begin
                        if (dest_in != m_ld) dc = 1;
                        if (is_tail_in) m_inpkt = 0;
                    end
                end
                if (stat_clear) begin
                    m_fc = 0; m_pc = 0; m_uf = 0; m_of = 0; m_dc = 0;
                end else begin
                    m_fc += 32'(send_in);
                    m_pc += 32'(send_in & is_tail_in);
                    m_uf |= uf; m_of |= of; m_dc |= dc;
                end
            end
            cyc++;
        end
    end

    // Monitor: pop expectations when due, compare monitor outputs
    initial begin
        bit due, cdue;
        wait (started);
        forever begin
            @(negedge clk);
            due = fq.size() > 0 && fq[0].due == cyc;
            if (due || send_out) begin
                chk("send_out", FW'(send_out), FW'(due));
                if (due) begin
                    chk("data_out", data_out, fq[0].d);
                    chk("dest_out", FW'(dest_out), FW'(fq[0].dst));
                    chk("tail_out", FW'(is_tail_out), FW'(fq[0].t));
                    void'(fq.pop_front());
                end
            end
            cdue = cqd.size() > 0 && cqd[0] == cyc;
            if (cdue || credit_out) begin
                chk("credit_out", FW'(credit_out), FW'(cdue));
                if (cdue) void'(cqd.pop_front());
            end
            chk("credits", FW'(credits_avail), FW'(m_cred));
            chk("flit_cnt", FW'(flit_count), FW'(m_fc));
            chk("pkt_cnt", FW'(pkt_count), FW'(m_pc));
            chk("err_uf", FW'(err_underflow), FW'(m_uf));
            chk("err_of", FW'(err_overflow), FW'(m_of));
            chk("err_dc", FW'(err_dest_chg), FW'(m_dc));
        end
    end

    // Stimulus
    initial begin
        logic [FW-1:0] rd;
        repeat (3) drive(0, '0, '0, 0, 0, 0, 1);
        started = 1;
        @(negedge clk);
        chk("rst_credits", FW'(credits_avail), FW'(8));
        chk("rst_send", FW'(send_out), FW'(0));
        chk("rst_flits", FW'(flit_count), FW'(0));

        drive(1, FW'(8'hA5), 6'h13, 1, 0, 0, 0);
        drive(0, '0, '0, 0, 1, 0, 0);
        idle(N + 2);
        @(negedge clk);
        chk("cred_back", FW'(credits_avail), FW'(8));

        repeat (8) drive(1, FW'($urandom), 6'h01, 1, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("cred_empty", FW'(credits_avail), FW'(0));
        chk("uf_clear", FW'(err_underflow), FW'(0));
        drive(1, FW'($urandom), 6'h01, 1, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("uf_set", FW'(err_underflow), FW'(1));
        chk("uf_hold0", FW'(credits_avail), FW'(0));

        drive(0, '0, '0, 0, 0, 1, 0);
        repeat (4) drive(0, '0, '0, 0, 1, 0, 0);
        idle(N + 1);
        @(negedge clk);
        chk("cred_4", FW'(credits_avail), FW'(4));
        chk("uf_cleared", FW'(err_underflow), FW'(0));
        drive(0, '0, '0, 0, 1, 0, 0);
        idle(N - 1);
        drive(1, FW'($urandom), 6'h02, 1, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("cred_both", FW'(credits_avail), FW'(4));
        repeat (4) drive(0, '0, '0, 0, 1, 0, 0);
        idle(N + 1);
        @(negedge clk);
        chk("cred_full", FW'(credits_avail), FW'(8));
        chk("of_clear", FW'(err_overflow), FW'(0));
        drive(0, '0, '0, 0, 1, 0, 0);
        idle(N + 1);
        @(negedge clk);
        chk("of_set", FW'(err_overflow), FW'(1));
        chk("of_hold8", FW'(credits_avail), FW'(8));

        drive(0, '0, '0, 0, 0, 1, 0);
        drive(1, FW'($urandom), 6'h05, 0, 0, 0, 0);
        drive(1, FW'($urandom), 6'h07, 0, 0, 0, 0);
        drive(1, FW'($urandom), 6'h05, 1, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("dc_set", FW'(err_dest_chg), FW'(1));
        chk("pkt_1", FW'(pkt_count), FW'(1));
        chk("flit_3", FW'(flit_count), FW'(3));
        drive(0, '0, '0, 0, 0, 1, 0);
        idle(1);
        @(negedge clk);
        chk("clr_dc", FW'(err_dest_chg), FW'(0));
        chk("clr_flit", FW'(flit_count), FW'(0));
        chk("clr_pkt", FW'(pkt_count), FW'(0));
        chk("clr_cred", FW'(credits_avail), FW'(5));

        drive(1, FW'(16'hBEEF), 6'h0A, 0, 1, 0, 0);
        drive(1, FW'(16'hCAFE), 6'h0A, 0, 0, 0, 1);
        idle(3);
        @(negedge clk);
        chk("rst_mid_cred", FW'(credits_avail), FW'(8));
        chk("rst_mid_flit", FW'(flit_count), FW'(0));

        for (int i = 0; i < 2000; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 1), rd, 6'($urandom_range(0, 3)),
                  ($urandom_range(0, 9) < 4), $urandom_range(0, 1),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 199) == 0));
        end
        idle(N + 3);
        @(negedge clk);
        chk("fwd_drain", FW'(fq.size()), FW'(0));
        chk("cred_drain", FW'(cqd.size()), FW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
